// File: rtl/spram_ctrl.sv
// Byte-addressed request/response front end for a 16-bit x 16K single-port SPRAM macro.
// Handles byte and 16-bit little-endian accesses; unaligned words take two SPRAM cycles.
module spram_ctrl #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-2:0] ram_ad,
    output logic [DW-1:0] ram_di,
    output logic [3:0]    ram_maskwe,
    output logic          ram_we,
    output logic          ram_cs,
    input  logic [DW-1:0] ram_do,
    output logic          ram_stdby,
    output logic          ram_sleep,
    output logic          ram_pwroff_n
);

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StCap} state_e;

    state_e        state_q, state_d;
    logic [AW-2:0] ram_ad_q, ram_ad_d;
    logic [DW-1:0] ram_di_q, ram_di_d;
    logic [3:0]    ram_maskwe_q, ram_maskwe_d;
    logic          ram_we_q, ram_we_d;
    logic          ram_cs_q, ram_cs_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    // Attributes of the request in flight, captured at accept.
    logic          we_q, we_d;
    logic          byte_q, byte_d;
    logic          lane_q, lane_d;
    logic          split_q, split_d;
    logic [AW-2:0] w_q, w_d;
    logic [7:0]    hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ram_ad_q     <= '0;
            ram_di_q     <= '0;
            ram_maskwe_q <= '0;
            ram_we_q     <= 1'b0;
            ram_cs_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= 1'b0;
            split_q      <= 1'b0;
            w_q          <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            ram_ad_q     <= ram_ad_d;
            ram_di_q     <= ram_di_d;
            ram_maskwe_q <= ram_maskwe_d;
            ram_we_q     <= ram_we_d;
            ram_cs_q     <= ram_cs_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            we_q         <= we_d;
            byte_q       <= byte_d;
            lane_q       <= lane_d;
            split_q      <= split_d;
            w_q          <= w_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ram_ad_d     = ram_ad_q;
        ram_di_d     = ram_di_q;
        ram_maskwe_d = ram_maskwe_q;
        ram_we_d     = ram_we_q;
        ram_cs_d     = ram_cs_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        we_d         = we_q;
        byte_d       = byte_q;
        lane_d       = lane_q;
        split_d      = split_q;
        w_d          = w_q;
        hold_d       = hold_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    byte_d   = req_byte;
                    lane_d   = req_addr[0];
                    split_d  = !req_byte && req_addr[0];
                    w_d      = req_addr[AW-1:1];
                    ram_ad_d = req_addr[AW-1:1];
                    ram_cs_d = 1'b1;
                    ram_we_d = req_we;
                    if (!req_we) begin
                        ram_maskwe_d = 4'b0000;
                    end else if (req_byte) begin
                        ram_di_d     = {req_wdata[7:0], req_wdata[7:0]};
                        ram_maskwe_d = req_addr[0] ? 4'b1100 : 4'b0011;
                    end else if (req_addr[0]) begin
                        // Both halves of a split write share this word: low byte
                        // goes high in the first access, high byte low in the second.
                        ram_di_d     = {req_wdata[7:0], req_wdata[15:8]};
                        ram_maskwe_d = 4'b1100;
                    end else begin
                        ram_di_d     = req_wdata;
                        ram_maskwe_d = 4'b1111;
                    end
                    state_d = StAcc1;
                end
            end
            StAcc1: begin
                if (split_q) begin
                    ram_ad_d     = w_q + {{(AW-2){1'b0}}, 1'b1};
                    ram_maskwe_d = we_q ? 4'b0011 : 4'b0000;
                    ram_we_d     = we_q;
                    ram_cs_d     = 1'b1;
                    state_d      = StAcc2;
                end else begin
                    ram_cs_d     = 1'b0;
                    ram_we_d     = 1'b0;
                    ram_maskwe_d = 4'b0000;
                    state_d      = StCap;
                end
            end
            StAcc2: begin
                hold_d       = ram_do[15:8];
                ram_cs_d     = 1'b0;
                ram_we_d     = 1'b0;
                ram_maskwe_d = 4'b0000;
                state_d      = StCap;
            end
            StCap: begin
                rsp_valid_d = 1'b1;
                if (we_q) begin
                    rsp_rdata_d = '0;
                end else if (byte_q) begin
                    rsp_rdata_d = {8'h00, lane_q ? ram_do[15:8] : ram_do[7:0]};
                end else if (split_q) begin
                    rsp_rdata_d = {ram_do[7:0], hold_q};
                end else begin
                    rsp_rdata_d = ram_do;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign ram_ad       = ram_ad_q;
    assign ram_di       = ram_di_q;
    assign ram_maskwe   = ram_maskwe_q;
    assign ram_we       = ram_we_q;
    assign ram_cs       = ram_cs_q;
    assign ram_stdby    = 1'b0;
    assign ram_sleep    = 1'b0;
    assign ram_pwroff_n = 1'b1;

endmodule

// File: tb/tb_spram_ctrl.sv
// Self-checking bench for spram_ctrl: table of directed accesses against a behavioural
// SPRAM macro, plus back-to-back and reset-abort sequences.
module tb_spram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_byte;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [13:0] ram_ad;
    logic [15:0] ram_di, ram_do;
    logic [3:0]  ram_maskwe;
    logic        ram_we, ram_cs, ram_stdby, ram_sleep, ram_pwroff_n;

    always #5 clk = ~clk;

    spram_ctrl #(.AW(15), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_maskwe(ram_maskwe), .ram_we(ram_we),
        .ram_cs(ram_cs), .ram_do(ram_do), .ram_stdby(ram_stdby), .ram_sleep(ram_sleep),
        .ram_pwroff_n(ram_pwroff_n)
    );

    function automatic logic [15:0] nib(input logic [3:0] m);
        return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
    endfunction

    // SPRAM macro: registered read, nibble-masked write, junk on ram_do after a write.
    logic [15:0] mem [16384];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                mem[ram_ad] <= (mem[ram_ad] & ~nib(ram_maskwe)) | (ram_di & nib(ram_maskwe));
                ram_do      <= 16'hDEAD;
            end else begin
                ram_do <= mem[ram_ad];
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic        bt;
        logic [14:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
        logic [13:0] ad0;
        logic [3:0]  m0;
        logic [15:0] di0;
        logic [13:0] ad1;
        logic [3:0]  m1;
        logic [15:0] di1;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic bt, input logic [14:0] addr,
                                input logic [15:0] wd, input logic [15:0] rd, input int lat,
                                input logic [13:0] ad0, input logic [3:0] m0,
                                input logic [15:0] di0, input logic [13:0] ad1,
                                input logic [3:0] m1, input logic [15:0] di1);
        vec_t v;
        v.we = we; v.bt = bt; v.addr = addr; v.wd = wd; v.rd = rd; v.lat = lat;
        v.ad0 = ad0; v.m0 = m0; v.di0 = di0; v.ad1 = ad1; v.m1 = m1; v.di1 = di1;
        return v;
    endfunction

    int          r_lat, r_ncs;
    logic [15:0] r_rdata, r_di0, r_di1;
    logic [13:0] r_ad0, r_ad1;
    logic [3:0]  r_m0, r_m1;

    // Issues one request and observes it until rsp_valid (bounded). Cycle 0 = accept cycle.
    task automatic do_req(input logic we, input logic bt, input logic [14:0] addr,
                          input logic [15:0] wd);
        int w;
        r_lat = 0; r_ncs = 0; r_rdata = '0;
        r_ad0 = '0; r_ad1 = '0; r_m0 = '0; r_m1 = '0; r_di0 = '0; r_di1 = '0;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("we_mask_without_cs",
                  {31'd0, (!ram_cs && (ram_we || (ram_maskwe != 4'b0)))}, 32'd0);
            if (ram_cs) begin
                if (r_ncs == 0) begin
                    r_ad0 = ram_ad; r_m0 = ram_maskwe; r_di0 = ram_di;
                end else begin
                    r_ad1 = ram_ad; r_m1 = ram_maskwe; r_di1 = ram_di;
                end
                r_ncs++;
            end
            if (rsp_valid) begin
                r_lat   = c;
                r_rdata = rsp_rdata;
                check("ready_with_rsp", {31'd0, req_ready}, 32'd1);
                break;
            end
            check("ready_while_busy", {31'd0, req_ready}, 32'd0);
        end
    endtask

    // Split write aborted by reset held low through the ACC1 (stage 1) or ACC2 (stage 2) cycle.
    task automatic rst_split(input int stage, input logic [14:0] addr, input logic [15:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (stage == 2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check($sformatf("rst%0d_ready", stage), {31'd0, req_ready}, 32'd1);
        check($sformatf("rst%0d_cs", stage), {31'd0, ram_cs}, 32'd0);
        check($sformatf("rst%0d_rsp", stage), {31'd0, rsp_valid}, 32'd0);
        check($sformatf("rst%0d_we_mask", stage), {27'd0, ram_we, ram_maskwe}, 32'd0);
        check($sformatf("rst%0d_ad", stage), {18'd0, ram_ad}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst%0d_no_rsp", stage), {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(1, 0, 15'h0100, 16'hA55A, 16'h0000, 3, 14'h0080, 4'hF, 16'hA55A,
                          0, 0, 0));
        vecs.push_back(mk(0, 0, 15'h0100, 16'h0000, 16'hA55A, 3, 14'h0080, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0201, 16'h0012, 16'h0000, 3, 14'h0100, 4'hC, 16'h1200,
                          0, 0, 0));
        vecs.push_back(mk(1, 1, 15'h0200, 16'h0034, 16'h0000, 3, 14'h0100, 4'h3, 16'h0034,
                          0, 0, 0));
        vecs.push_back(mk(0, 0, 15'h0200, 16'h0000, 16'h1234, 3, 14'h0100, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15'h0201, 16'h0000, 16'h0012, 3, 14'h0100, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15'h0200, 16'h0000, 16'h0034, 3, 14'h0100, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 15'h0300, 16'h5566, 16'h0000, 3, 14'h0180, 4'hF, 16'h5566,
                          0, 0, 0));
        vecs.push_back(mk(1, 0, 15'h0301, 16'hBEAD, 16'h0000, 4, 14'h0180, 4'hC, 16'hAD00,
                          14'h0181, 4'h3, 16'h00BE));
        vecs.push_back(mk(0, 0, 15'h0301, 16'h0000, 16'hBEAD, 4, 14'h0180, 4'h0, 0,
                          14'h0181, 4'h0, 0));
        vecs.push_back(mk(0, 0, 15'h0300, 16'h0000, 16'hAD66, 3, 14'h0180, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 15'h7FFF, 16'hC0DE, 16'h0000, 4, 14'h3FFF, 4'hC, 16'hDE00,
                          14'h0000, 4'h3, 16'h00C0));
        vecs.push_back(mk(0, 0, 15'h7FFF, 16'h0000, 16'hC0DE, 4, 14'h3FFF, 4'h0, 0,
                          14'h0000, 4'h0, 0));
        vecs.push_back(mk(0, 1, 15'h7FFF, 16'h0000, 16'h00DE, 3, 14'h3FFF, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15'h0000, 16'h0000, 16'h00C0, 3, 14'h0000, 4'h0, 0, 0, 0, 0));

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("reset_cs_we_mask", {26'd0, ram_cs, ram_we, ram_maskwe}, 32'd0);
        check("reset_ad_di", {2'd0, ram_ad, ram_di}, 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].we, vecs[i].bt, vecs[i].addr, vecs[i].wd);
            check($sformatf("v%0d_latency", i), r_lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), {16'd0, r_rdata}, {16'd0, vecs[i].rd});
            check($sformatf("v%0d_cs_cycles", i), r_ncs, vecs[i].lat - 2);
            check($sformatf("v%0d_ad0", i), {18'd0, r_ad0}, {18'd0, vecs[i].ad0});
            check($sformatf("v%0d_mask0", i), {28'd0, r_m0}, {28'd0, vecs[i].m0});
            if (vecs[i].we)
                check($sformatf("v%0d_di0", i), {16'd0, r_di0 & nib(vecs[i].m0)},
                      {16'd0, vecs[i].di0 & nib(vecs[i].m0)});
            if (vecs[i].lat == 4) begin
                check($sformatf("v%0d_ad1", i), {18'd0, r_ad1}, {18'd0, vecs[i].ad1});
                check($sformatf("v%0d_mask1", i), {28'd0, r_m1}, {28'd0, vecs[i].m1});
                if (vecs[i].we)
                    check($sformatf("v%0d_di1", i), {16'd0, r_di1 & nib(vecs[i].m1)},
                          {16'd0, vecs[i].di1 & nib(vecs[i].m1)});
            end
        end

        // Back-to-back aligned reads with req_valid held: accepts every third cycle.
        begin
            int na, nr;
            na = 0; nr = 0;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 15'h0100;
            for (int c = 0; c < 15; c++) begin
                if (c > 0) @(negedge clk);
                check($sformatf("b2b_ready_c%0d", c), {31'd0, req_ready},
                      {31'd0, ((c % 3) == 0) || (c > 12)});
                if (rsp_valid) begin
                    check($sformatf("b2b_rsp%0d_cycle", nr), c, 3 * (nr + 1));
                    check($sformatf("b2b_rsp%0d_rdata", nr), {16'd0, rsp_rdata}, 32'h0000A55A);
                    nr++;
                end
                if (req_ready && req_valid) na++;
                @(posedge clk);
                if (na == 4) #1 req_valid = 1'b0;
            end
            check("b2b_accepts", na, 4);
            check("b2b_responses", nr, 4);
        end

        // Reset while the second half of a split write is on the bus.
        do_req(1, 0, 15'h0500, 16'h1122);
        rst_split(2, 15'h0501, 16'h7788);
        do_req(0, 0, 15'h0500, 16'h0000);
        check("rst2_first_half_kept", {16'd0, r_rdata}, 32'h00008822);

        // Reset before the second half is issued: only the high byte of word w lands.
        do_req(1, 0, 15'h0600, 16'h1122);
        do_req(1, 0, 15'h0602, 16'h3344);
        rst_split(1, 15'h0601, 16'h99AA);
        do_req(0, 0, 15'h0600, 16'h0000);
        check("rst1_high_byte_written", {16'd0, r_rdata}, 32'h0000AA22);
        do_req(0, 0, 15'h0602, 16'h0000);
        check("rst1_next_word_untouched", {16'd0, r_rdata}, 32'h00003344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spram_ctrl.md
Name: spram_ctrl

Overview:
- Byte-addressed request/response front end for one 16-bit x 16K single-port SPRAM macro (32 KB).
- Sits between the eForth core's memory port and the SPRAM instance. Drives the macro's address, data, nibble write mask, WE and CS, and consumes its registered read data.
- Supports byte and 16-bit accesses, little-endian. An unaligned 16-bit access is split into two SPRAM cycles, with read data reassembled.

Parameters:
- AW, 15, byte address width (word index = AW-1 = 14 bits).
- DW, 16, data width. Fixed at 16; other values unsupported.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_byte  in  1  1 = byte access, 0 = 16-bit access.
- req_addr  in  AW  byte address.
- req_wdata  in  16  write data; byte writes use [7:0].
- rsp_valid  out  1  one-cycle pulse, request complete (reads and writes).
- rsp_rdata  out  16  read result; 0 for writes; byte reads zero-extended.
- ram_ad  out  14  SPRAM word address.
- ram_di  out  16  SPRAM write data.
- ram_maskwe  out  4  SPRAM nibble write enables.
- ram_we  out  1  SPRAM write enable.
- ram_cs  out  1  SPRAM chip select.
- ram_do  in  16  SPRAM read data, valid the cycle after a read CS cycle.
- ram_stdby, ram_sleep  out  1  tied 0.
- ram_pwroff_n  out  1  tied 1.

Behaviour:
- Clock and reset: one clock clk; rst_n synchronous, active-low.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_cs=0, ram_we=0, ram_maskwe=0, ram_ad=0, ram_di=0.
- All ram_* and rsp_* outputs are registered. req_ready = (state==IDLE).
- Handshake:
  - Accept when req_valid & req_ready; req_* fields are sampled only at accept.
  - req_valid while not ready is ignored; the requester holds it.
- Address mapping:
  - w = addr[14:1], lane = addr[0]; lane 0 = ram bits [7:0], lane 1 = [15:8].
  - split = !req_byte & addr[0].
- Access encoding (value of ram_* during the access cycle):
  - byte write, lane 0: di={wd[7:0],wd[7:0]}, mask 0011.
  - byte write, lane 1: same di, mask 1100.
  - aligned word write: di=wd, mask 1111.
  - split write:
    - first access: ad=w, mask 1100, di[15:8]=wd[7:0].
    - second access: ad=(w+1) mod 16384, mask 0011, di[7:0]=wd[15:8].
  - reads: we=0, mask 0000.
  - ram_we and nonzero mask only ever occur with ram_cs=1.
- FSM:
  - IDLE: on accept, load the first access into ram_* (cs=1) and go to ACC1.
  - ACC1: if split, load the second access and go to ACC2; else set cs=0, we=0, mask=0 and go to CAP.
  - ACC2: capture the first-read byte ram_do[15:8] into a holding register; set cs=0, we=0, mask=0; go to CAP.
  - CAP: form rsp_rdata from ram_do; set rsp_valid=1; go to IDLE.
  - rsp_valid is high in the first IDLE cycle and req_ready is also high then, so back-to-back accepts are allowed.
- Read assembly:
  - byte read: {8'h00, lane ? do[15:8] : do[7:0]}.
  - aligned word read: do.
  - split read: {do[7:0] of word w+1, held byte}.
- Writes ignore ram_do (the macro returns junk after a write) and return rsp_rdata=0.
- Latency (accept cycle = 0): rsp_valid in cycle 3 for non-split accesses, cycle 4 for split. Throughput is one request per 3 or 4 cycles.
- Wrap-around: a split at addr 0x7FFF touches word 0x3FFF then word 0x0000.
- Between accesses ram_ad and ram_di hold their last values.
- Reset mid-operation:
  - return to IDLE with reset values; no response is issued.
  - a write whose CS cycle already completed stays committed.
  - a split write interrupted after ACC1 leaves only the high byte written.

Test Plan:
- Aligned word write 0x0100<=0xA55A, then read 0x0100:
  - write: ram_ad=0x0080, mask 1111, rsp_valid in cycle 3.
  - read: rsp_rdata=0xA55A in cycle 3.
- Byte writes 0x0201<=0x12 and 0x0200<=0x34, then word read 0x0200:
  - masks 1100 then 0011.
  - read returns 0x1234.
  - byte read 0x0201 returns 0x0012.
- Split word write 0x0301<=0xBEAD, then read 0x0301:
  - write: two CS cycles, ad 0x0180 mask 1100 then ad 0x0181 mask 0011.
  - read: rsp_rdata=0xBEAD in cycle 4.
  - word read 0x0300 shows high byte 0xAD, low byte unchanged.
- Wrap: word write 0x7FFF<=0xC0DE:
  - word 0x3FFF gets [15:8]=0xDE; word 0x0000 gets [7:0]=0xC0.
  - read 0x7FFF returns 0xC0DE.
- Back-to-back: hold req_valid for 4 aligned reads:
  - accepts in cycles 0, 3, 6, 9; rsp_valid in cycles 3, 6, 9, 12.
  - req_ready never high in ACC1/ACC2/CAP.
- rst_n low during ACC2 of a split write:
  - next cycle: IDLE, ram_cs=0, rsp_valid=0, req_ready=1.
  - no rsp_valid is ever produced for the aborted request.
